// File: rtl/mips_pkg.sv
// mips_pkg: shared multiplier types and sizing for the mult_sequencer block.
package mips_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_e;
endpackage

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: pipeline-to-multiplier request and hi/lo result bundle.
interface mult_sequencer_if;
  logic                            start_mult;
  logic                            mult_sign;
  logic [mips_pkg::MULT_WIDTH-1:0] src_a;
  logic [mips_pkg::MULT_WIDTH-1:0] src_b;
  logic                            hilo_read;
  logic [mips_pkg::MULT_WIDTH-1:0] hi;
  logic [mips_pkg::MULT_WIDTH-1:0] lo;
  logic                            busy;
  logic                            done;
  logic                            stall;
  modport master (output start_mult, mult_sign, src_a, src_b, hilo_read,
                  input  hi, lo, busy, done, stall);
  modport slave  (input  start_mult, mult_sign, src_a, src_b, hilo_read,
                  output hi, lo, busy, done, stall);
endinterface

// File: rtl/mult_abs.sv
// mult_abs: conditional absolute value; -2^31 maps to 2^31 read as unsigned.
module mult_abs
  import mips_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] x,
  input  logic                  en,
  output logic [MULT_WIDTH-1:0] y
);
  assign y = (en && x[MULT_WIDTH-1]) ? -x : x;
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative shift-add 32x32 multiplier feeding hi/lo registers.
// Define MULT_EARLY_TERM_EN to leave RUN as soon as the multiplier is exhausted.
module mult_sequencer
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mult_sequencer_if.slave bus
);
  localparam int CW = $clog2(MULT_STEPS);
  mult_state_e               state, state_n;
  logic [2*MULT_WIDTH-1:0]   mcand, acc;
  logic [MULT_WIDTH-1:0]     mplier, abs_a, abs_b, hi, lo;
  logic [CW-1:0]             count;
  logic                      neg, last, busy;
  mult_abs u_abs_a (.x(bus.src_a), .en(bus.mult_sign), .y(abs_a));
  mult_abs u_abs_b (.x(bus.src_b), .en(bus.mult_sign), .y(abs_b));
`ifdef MULT_EARLY_TERM_EN
  // remaining multiplier bits after this step's shift are all zero
  assign last = count == CW'(MULT_STEPS - 1) || mplier[MULT_WIDTH-1:1] == '0;
`else
  assign last = count == CW'(MULT_STEPS - 1);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start_mult) state_n = RUN;
      RUN:     if (last) state_n = FIX;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE && bus.start_mult) begin
      mcand  <= {{MULT_WIDTH{1'b0}}, abs_a};
      mplier <= abs_b;
      acc    <= '0;
      neg    <= bus.mult_sign & (bus.src_a[MULT_WIDTH-1] ^ bus.src_b[MULT_WIDTH-1]);
      count  <= '0;
    end else if (state == RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end else if (state == FIX) begin
      {hi, lo} <= neg ? -acc : acc;
    end
  assign busy      = state == RUN || state == FIX;
  assign bus.busy  = busy;
  assign bus.done  = state == DONE;
  assign bus.stall = busy & (bus.hilo_read | bus.start_mult);
  assign bus.hi    = hi;
  assign bus.lo    = lo;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed literal cases plus random traffic against a cycle-level product model.
module tb_mult_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mult_sequencer_if bus();
  mult_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    return s ? 64'(sa * sb) : ua * ub;
  endfunction
  // cycles from the accepting edge to the done cycle
  function automatic int lat_of(input logic s, input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m = (s && b[31]) ? -b : b;
    int n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return n + 2;
`else
    return (s === 1'bx || b === 'x) ? 34 : 34;
`endif
  endfunction
  function automatic logic [31:0] pick();
    int r = $urandom_range(0, 5);
    return r == 0 ? 32'h0 : r == 1 ? 32'h1 : r == 2 ? 32'hFFFF_FFFF :
           r == 3 ? 32'h8000_0000 : r == 4 ? 32'h7FFF_FFFF : 32'($urandom);
  endfunction
  bit          m_act = 1'b0;
  int          m_t = 0;
  int          m_lat = 34;
  logic [63:0] m_res = '0;
  logic [63:0] m_hl = '0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_hl  <= '0;
    end else if (!m_act) begin
      if (bus.start_mult) begin
        m_act <= 1'b1;
        m_t   <= 1;
        m_lat <= lat_of(bus.mult_sign, bus.src_b);
        m_res <= prod(bus.mult_sign, bus.src_a, bus.src_b);
      end
    end else begin
      if (m_t == m_lat - 1) m_hl <= m_res;
      if (m_t == m_lat) m_act <= 1'b0;
      else m_t <= m_t + 1;
    end
  wire e_busy = m_act && (m_t < m_lat);
  wire e_done = m_act && (m_t == m_lat);
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("done", 64'(bus.done), 64'(e_done));
      chk("stall", 64'(bus.stall), 64'(e_busy & (bus.hilo_read | bus.start_mult)));
      chk("hilo", {bus.hi, bus.lo}, m_hl);
    end
  end
  task automatic op(input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [63:0] exp, input int lat, input string name);
    int c;
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.mult_sign  = s;
    bus.src_a      = a;
    bus.src_b      = b;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.src_a      = $urandom;
    bus.src_b      = $urandom;
    c = 1;
    while (!bus.done && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_lat"}, 64'(c), 64'(lat));
    chk(name, {bus.hi, bus.lo}, exp);
  endtask
`ifdef MULT_EARLY_TERM_EN
  localparam int L35 = 5;
  localparam int L71 = 3;
`else
  localparam int L35 = 34;
  localparam int L71 = 34;
`endif
  initial begin
    int nst, nd, l79;
    bus.start_mult = 1'b1;
    bus.mult_sign  = 1'b0;
    bus.src_a      = 32'd3;
    bus.src_b      = 32'd5;
    bus.hilo_read  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.hilo_read  = 1'b0;
    reset          = 1'b0;
    op(1'b0, 32'd3, 32'd5, 64'hF, L35, "u3x5");
    op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, lat_of(1'b0, 32'hFFFF_FFFF), "uffxff");
    op(1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, lat_of(1'b1, 32'd3), "sm2x3");
    op(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, lat_of(1'b1, 32'h8000_0000), "smin2");
    op(1'b0, 32'd7, 32'd1, 64'd7, L71, "u7x1");
    op(1'b0, 32'd7, 32'd0, 64'd0, L71, "u7x0");
    // 7*9 with hilo_read held and a stray start inside the busy window
    l79 = lat_of(1'b0, 32'd9);
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.mult_sign  = 1'b0;
    bus.src_a      = 32'd7;
    bus.src_b      = 32'd9;
    bus.hilo_read  = 1'b1;
    @(negedge clk);
    bus.src_a = 32'd2;
    bus.src_b = 32'd2;
    nst = 0;
    for (int c = 1; c <= l79; c++) begin
      bus.start_mult = (c == 5);
      #1;
      if (c < l79) nst += int'(bus.stall);
      else begin
        chk("stall_at_done", 64'(bus.stall), 64'd0);
        chk("done_7x9", 64'(bus.done), 64'd1);
      end
      if (c < l79) @(negedge clk);
    end
    chk("stall_cycles", 64'(nst), 64'(l79 - 1));
    chk("res_7x9", {bus.hi, bus.lo}, 64'h3F);
    bus.hilo_read = 1'b0;
    // abort at cycle k+10
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.src_a      = 32'h1234;
    bus.src_b      = 32'h8765_4321;
    @(negedge clk);
    bus.start_mult = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      nd += int'(bus.done);
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op(1'b0, 32'd6, 32'd7, 64'd42, lat_of(1'b0, 32'd7), "after_rst");
    repeat (3000) begin
      @(negedge clk);
      bus.start_mult = $urandom_range(0, 3) == 0;
      bus.mult_sign  = 1'($urandom);
      bus.src_a      = pick();
      bus.src_b      = pick();
      bus.hilo_read  = 1'($urandom);
    end
    bus.start_mult = 1'b0;
    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
